// File: rtl/spram_uart_dump_pkg.sv
// Shared SPRAM geometry and dump/load FSM encoding, reused by the future uart_rx -> SPRAM loader.
package spram_uart_dump_pkg;

  localparam int unsigned SPRAM_ADDR_WIDTH = 14;
  localparam int unsigned SPRAM_DATA_WIDTH = 16;
  localparam int unsigned SPRAM_DEPTH      = 16384;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FETCH       = 3'd1,
    ST_WAIT        = 3'd2,
    ST_SEND_FIRST  = 3'd3,
    ST_SEND_SECOND = 3'd4,
    ST_FINISH      = 3'd5
  } dump_state_e;

  // Select the high or low byte of a 16-bit SPRAM word.
  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic high);
    return high ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/spram_uart_dump.sv
// Streams a contiguous range of SPRAM words to uart_tx as byte pairs, hiding the SPRAM read latency.
module spram_uart_dump
  import spram_uart_dump_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SPRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SPRAM_DATA_WIDTH,
  parameter bit          HIGH_FIRST = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [7:0]            byte_to_send,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done
);

  dump_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] address_next;
  logic [ADDR_WIDTH:0]   remaining, remaining_next;
  logic [DATA_WIDTH-1:0] word, word_next;
  logic [7:0]            byte_next;
  logic                  valid_next, busy_next, done_next;

  // State, datapath and outputs all registered; outputs follow the next state so they align with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      mem_address  <= '0;
      remaining    <= '0;
      word         <= '0;
      byte_to_send <= 8'h00;
      valid        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      mem_address  <= address_next;
      remaining    <= remaining_next;
      word         <= word_next;
      byte_to_send <= byte_next;
      valid        <= valid_next;
      busy         <= busy_next;
      done         <= done_next;
    end
  end

  // Next-state and datapath decode; SEND states only advance on ready since valid is high there.
  always_comb begin
    state_next     = state;
    address_next   = mem_address;
    remaining_next = remaining;
    word_next      = word;
    byte_next      = byte_to_send;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            address_next   = start_address;
            remaining_next = word_count;
            state_next     = ST_FETCH;
          end else begin
            state_next = ST_FINISH;
          end
        end
      end
      ST_FETCH: state_next = ST_WAIT;
      ST_WAIT: begin
        word_next  = mem_data;
        byte_next  = pick_byte(mem_data[15:0], HIGH_FIRST);
        state_next = ST_SEND_FIRST;
      end
      ST_SEND_FIRST: begin
        if (ready) begin
          byte_next  = pick_byte(word[15:0], !HIGH_FIRST);
          state_next = ST_SEND_SECOND;
        end
      end
      ST_SEND_SECOND: begin
        if (ready) begin
          if (remaining == (ADDR_WIDTH+1)'(1)) begin
            state_next = ST_FINISH;
          end else begin
            remaining_next = remaining - (ADDR_WIDTH+1)'(1);
            address_next   = mem_address + ADDR_WIDTH'(1);
            state_next     = ST_FETCH;
          end
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase

    valid_next = (state_next == ST_SEND_FIRST) || (state_next == ST_SEND_SECOND);
    busy_next  = (state_next != ST_IDLE);
    done_next  = (state_next == ST_FINISH);
  end

endmodule

// File: tb/tb_spram_uart_dump.sv
// Directed bench for spram_uart_dump: byte order, latency, wrap, zero count, stall, async reset.
module tb_spram_uart_dump;

  logic        clock;
  logic        reset_n;

  logic        start0, ready0, valid0, busy0, done0;
  logic [13:0] start_address0, mem_address0;
  logic [14:0] word_count0;
  logic [15:0] mem_data0;
  logic [7:0]  byte0;

  logic        start1, ready1, valid1, busy1, done1;
  logic [13:0] start_address1, mem_address1;
  logic [14:0] word_count1;
  logic [15:0] mem_data1;
  logic [7:0]  byte1;

  logic [15:0] mem0 [0:16383];
  logic [15:0] mem1 [0:16383];

  int vectors;
  int miscompares;

  logic [7:0] got[$];
  int first_valid, done_cyc, busy_cycles, stall_bad;
  logic busy_after;
  logic [7:0] held_byte;

  spram_uart_dump #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .HIGH_FIRST(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .start_address(start_address0),
    .word_count(word_count0), .mem_address(mem_address0), .mem_data(mem_data0),
    .byte_to_send(byte0), .valid(valid0), .ready(ready0), .busy(busy0), .done(done0)
  );

  spram_uart_dump #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .HIGH_FIRST(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .start_address(start_address1),
    .word_count(word_count1), .mem_address(mem_address1), .mem_data(mem_data1),
    .byte_to_send(byte1), .valid(valid1), .ready(ready1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  // SPRAM read model: address registered at the edge, data visible the following cycle.
  always @(posedge clock) begin
    mem_data0 <= mem0[mem_address0];
    mem_data1 <= mem1[mem_address1];
  end

  // Runs one dump on instance sel; cycle k is the cycle after start edge k-1.
  task automatic run_dump(input bit sel, input logic [13:0] addr, input logic [14:0] cnt,
                          input int stall_from, input int stall_len, input int pulse_at,
                          input int abort_at);
    logic v, b, d;
    logic [7:0] by;
    got.delete();
    first_valid = -1; done_cyc = -1; busy_cycles = 0; stall_bad = 0;
    busy_after = 1'bx; held_byte = 8'hxx;
    @(negedge clock);
    if (sel) begin start1 = 1'b1; start_address1 = addr; word_count1 = cnt; end
    else     begin start0 = 1'b1; start_address0 = addr; word_count0 = cnt; end
    @(negedge clock);
    start0 = 1'b0; start1 = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (!sel) begin
        ready0 = !(k >= stall_from && k < stall_from + stall_len);
        start0 = (k == pulse_at);
        if (k == pulse_at) begin start_address0 = 14'h0; word_count0 = 15'd5; end
      end
      v  = sel ? valid1 : valid0;
      b  = sel ? busy1  : busy0;
      d  = sel ? done1  : done0;
      by = sel ? byte1  : byte0;
      if (k == stall_from) held_byte = by;
      if (k > stall_from && k < stall_from + stall_len + 1)
        if (!(v === 1'b1 && by === held_byte && mem_address0 === addr)) stall_bad++;
      if (v === 1'b1 && first_valid < 0) first_valid = k;
      if (v === 1'b1 && (sel ? ready1 : ready0)) got.push_back(by);
      if (done_cyc >= 0 && k == done_cyc + 1) begin busy_after = b; break; end
      if (b === 1'b1) busy_cycles++;
      if (d === 1'b1) done_cyc = k;
      if (k == abort_at) break;
      @(negedge clock);
    end
    start0 = 1'b0; ready0 = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done0); end
    vectors++; if (byte0 !== 8'h00) begin miscompares++; $display("FAIL reset_byte got %h want 00", byte0); end
    vectors++; if (mem_address0 !== 14'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0000", mem_address0); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    vectors++; if (busy0 !== 1'b0 || valid0 !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset busy %b valid %b want 0 0", busy0, valid0); end
  endtask

  task automatic test_single;
    logic [7:0] exp [$];
    exp = '{8'h58, 8'hAC};
    mem0[14'h7] = 16'hAC58;
    run_dump(1'b0, 14'h7, 15'd1, -100, 0, -1, -1);
    vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL single_count got %0d want 2", got.size()); end
    foreach (exp[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp[i]) begin miscompares++; $display("FAIL single_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
    end
    vectors++; if (first_valid != 3) begin miscompares++; $display("FAIL single_first_valid got %0d want 3", first_valid); end
    vectors++; if (done_cyc != 5) begin miscompares++; $display("FAIL single_done_cycle got %0d want 5", done_cyc); end
    vectors++; if (busy_cycles != 5) begin miscompares++; $display("FAIL single_busy_cycles got %0d want 5", busy_cycles); end
    vectors++; if (busy_after !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall got %b want 0", busy_after); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp [$];
    exp = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55};
    mem0[14'h3FFE] = 16'h1122; mem0[14'h3FFF] = 16'h3344; mem0[14'h0000] = 16'h5566;
    run_dump(1'b0, 14'h3FFE, 15'd3, -100, 0, -1, -1);
    vectors++; if (got.size() != 6) begin miscompares++; $display("FAIL wrap_count got %0d want 6", got.size()); end
    foreach (exp[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp[i]) begin miscompares++; $display("FAIL wrap_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
    end
    vectors++; if (done_cyc != 13) begin miscompares++; $display("FAIL wrap_done_cycle got %0d want 13", done_cyc); end
    vectors++; if (mem_address0 !== 14'h0000) begin miscompares++; $display("FAIL wrap_address got %h want 0000", mem_address0); end
  endtask

  task automatic test_zero_count;
    run_dump(1'b0, 14'h123, 15'd0, -100, 0, -1, -1);
    vectors++; if (done_cyc != 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
    vectors++; if (first_valid != -1) begin miscompares++; $display("FAIL zero_valid_seen got cycle %0d want none", first_valid); end
    vectors++; if (busy_cycles != 1) begin miscompares++; $display("FAIL zero_busy_cycles got %0d want 1", busy_cycles); end
    vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL zero_bytes got %0d want 0", got.size()); end
  endtask

  task automatic test_stall;
    logic [7:0] exp [$];
    exp = '{8'hEF, 8'hBE, 8'h88, 8'h77};
    mem0[14'h100] = 16'hBEEF; mem0[14'h101] = 16'h7788;
    // ready low in cycles 4..13 (SEND_SECOND of the first word), extra start in cycle 6
    run_dump(1'b0, 14'h100, 15'd2, 4, 10, 6, -1);
    vectors++; if (held_byte !== 8'hBE) begin miscompares++; $display("FAIL stall_held_byte got %h want BE", held_byte); end
    vectors++; if (stall_bad != 0) begin miscompares++; $display("FAIL stall_stability got %0d bad cycles want 0", stall_bad); end
    foreach (exp[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp[i]) begin miscompares++; $display("FAIL stall_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
    end
    vectors++; if (done_cyc != 19) begin miscompares++; $display("FAIL stall_done_cycle got %0d want 19", done_cyc); end
    vectors++; if (busy_after !== 1'b0) begin miscompares++; $display("FAIL stall_start_ignored busy got %b want 0", busy_after); end
  endtask

  task automatic test_high_first;
    mem1[14'h7] = 16'hAC58;
    run_dump(1'b1, 14'h7, 15'd1, -100, 0, -1, -1);
    vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL high_count got %0d want 2", got.size()); end
    vectors++; if (got.size() < 1 || got[0] !== 8'hAC) begin miscompares++; $display("FAIL high_byte0 got %h want AC", (got.size() > 0) ? got[0] : 8'hxx); end
    vectors++; if (got.size() < 2 || got[1] !== 8'h58) begin miscompares++; $display("FAIL high_byte1 got %h want 58", (got.size() > 1) ? got[1] : 8'hxx); end
    vectors++; if (done_cyc != 5) begin miscompares++; $display("FAIL high_done_cycle got %0d want 5", done_cyc); end
  endtask

  task automatic test_reset_mid;
    logic done_seen;
    mem0[14'h20] = 16'h5A3C;
    run_dump(1'b0, 14'h20, 15'd1, -100, 0, -1, 3);
    vectors++; if (valid0 !== 1'b1 || byte0 !== 8'h3C) begin miscompares++; $display("FAIL mid_pre_valid got %b/%h want 1/3C", valid0, byte0); end
    reset_n = 1'b0;
    #1;
    vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid got %b want 0", valid0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy got %b want 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL mid_reset_done got %b want 0", done0); end
    vectors++; if (byte0 !== 8'h00 || mem_address0 !== 14'h0) begin miscompares++; $display("FAIL mid_reset_regs got %h/%h want 00/0000", byte0, mem_address0); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (done0 === 1'b1 || busy0 === 1'b1) done_seen = 1'b1;
    end
    vectors++; if (done_seen !== 1'b0) begin miscompares++; $display("FAIL mid_no_done got activity %b want 0", done_seen); end
    run_dump(1'b0, 14'h7, 15'd1, -100, 0, -1, -1);
    vectors++; if (got.size() != 2 || got[0] !== 8'h58 || got[1] !== 8'hAC) begin miscompares++; $display("FAIL mid_redump got %0d bytes want 58 AC", got.size()); end
    vectors++; if (done_cyc != 5) begin miscompares++; $display("FAIL mid_redump_done got %0d want 5", done_cyc); end
  endtask

  initial begin
    clock = 1'b0;
    reset_n = 1'b0;
    vectors = 0; miscompares = 0;
    start0 = 1'b0; ready0 = 1'b1; start_address0 = '0; word_count0 = '0;
    start1 = 1'b0; ready1 = 1'b1; start_address1 = '0; word_count1 = '0;
    for (int i = 0; i < 16384; i++) begin mem0[i] = 16'h0; mem1[i] = 16'h0; end
    test_reset();
    test_single();
    test_wrap();
    test_zero_count();
    test_stall();
    test_high_first();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
